// File: rtl/async_sram_ctrl.sv
// Asynchronous SRAM controller: converts single-word read/write requests into
// registered SRAM strobe sequences with configurable pulse and turnaround timing.
module async_sram_ctrl #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 18,
  parameter int ID_W       = 2,
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 1,
  parameter int TURNAROUND = 1
) (
  input  logic                  clock,
  input  logic                  rst,
  output logic                  mem_waitrequest,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ID_W-1:0]       mem_id,
  input  logic [ADDR_W-1:0]     mem_address,
  input  logic [DATA_W-1:0]     mem_writedata,
  input  logic [DATA_W/8-1:0]   mem_writedatamask,
  output logic [DATA_W-1:0]     mem_readdata,
  output logic [ID_W-1:0]       mem_readdataid,
  output logic                  mem_readdatavalid,
  output logic [ADDR_W-1:0]     sram_a,
  output logic [DATA_W-1:0]     sram_d_out,
  output logic                  sram_d_oe,
  input  logic [DATA_W-1:0]     sram_d_in,
  output logic                  sram_cs_n,
  output logic                  sram_oe_n,
  output logic                  sram_we_n,
  output logic [DATA_W/8-1:0]   sram_be_n
);

  localparam int BE_W     = DATA_W / 8;
  localparam int MAX_RW   = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int MAX_WAIT = (MAX_RW > TURNAROUND) ? MAX_RW : TURNAROUND;
  // The counter is loaded with (wait - 1) and leaves its state on zero.
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_WAIT - 1);
  localparam logic [CNT_W-1:0] TA_LOAD = CNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WSETUP,
    WPULSE,
    WHOLD,
    TURN
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [ADDR_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              d_oe_reg, d_oe_next;
  logic              cs_n_reg, cs_n_next;
  logic              oe_n_reg, oe_n_next;
  logic              we_n_reg, we_n_next;
  logic [BE_W-1:0]   be_n_reg, be_n_next;
  logic [ID_W-1:0]   id_reg, id_next;
  logic [DATA_W-1:0] rdata_reg, rdata_next;
  logic [ID_W-1:0]   rid_reg, rid_next;
  logic              rvalid_reg, rvalid_next;

  logic [BE_W-1:0]   wr_be_n;
  logic              wr_any;

  genvar gi;
  generate
    for (gi = 0; gi < BE_W; gi++) begin : g_be
      assign wr_be_n[gi] = ~mem_writedatamask[gi];
    end
  endgenerate

  // An all-zero mask is still accepted but never touches the SRAM.
  assign wr_any = |mem_writedatamask;

  assign mem_waitrequest = (state_reg != IDLE) || rst;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    dout_next   = dout_reg;
    id_next     = id_reg;
    rdata_next  = rdata_reg;
    rid_next    = rid_reg;
    rvalid_next = 1'b0;
    d_oe_next   = 1'b0;
    cs_n_next   = 1'b1;
    oe_n_next   = 1'b1;
    we_n_next   = 1'b1;
    be_n_next   = '1;

    unique case (state_reg)
      IDLE: begin
        if (mem_write) begin
          if (wr_any) begin
            state_next = WSETUP;
            a_next     = mem_address;
            dout_next  = mem_writedata;
            be_n_next  = wr_be_n;
            cs_n_next  = 1'b0;
            d_oe_next  = 1'b1;
          end
        end else if (mem_read) begin
          state_next = READ;
          cnt_next   = RD_LOAD;
          a_next     = mem_address;
          id_next    = mem_id;
          cs_n_next  = 1'b0;
          oe_n_next  = 1'b0;
          be_n_next  = '0;
        end
      end

      READ: begin
        if (cnt_reg == '0) begin
          state_next  = IDLE;
          rdata_next  = sram_d_in;
          rid_next    = id_reg;
          rvalid_next = 1'b1;
        end else begin
          cnt_next  = cnt_reg - CNT_W'(1);
          cs_n_next = 1'b0;
          oe_n_next = 1'b0;
          be_n_next = '0;
        end
      end

      WSETUP: begin
        state_next = WPULSE;
        cnt_next   = WR_LOAD;
        cs_n_next  = 1'b0;
        d_oe_next  = 1'b1;
        we_n_next  = 1'b0;
        be_n_next  = be_n_reg;
      end

      WPULSE: begin
        cs_n_next = 1'b0;
        d_oe_next = 1'b1;
        be_n_next = be_n_reg;
        if (cnt_reg == '0) begin
          state_next = WHOLD;
        end else begin
          cnt_next  = cnt_reg - CNT_W'(1);
          we_n_next = 1'b0;
        end
      end

      WHOLD: begin
        if (TURNAROUND > 0) begin
          state_next = TURN;
          cnt_next   = TA_LOAD;
        end else begin
          state_next = IDLE;
        end
      end

      TURN: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - CNT_W'(1);
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      a_reg      <= '0;
      dout_reg   <= '0;
      d_oe_reg   <= 1'b0;
      cs_n_reg   <= 1'b1;
      oe_n_reg   <= 1'b1;
      we_n_reg   <= 1'b1;
      be_n_reg   <= '1;
      id_reg     <= '0;
      rdata_reg  <= '0;
      rid_reg    <= '0;
      rvalid_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      a_reg      <= a_next;
      dout_reg   <= dout_next;
      d_oe_reg   <= d_oe_next;
      cs_n_reg   <= cs_n_next;
      oe_n_reg   <= oe_n_next;
      we_n_reg   <= we_n_next;
      be_n_reg   <= be_n_next;
      id_reg     <= id_next;
      rdata_reg  <= rdata_next;
      rid_reg    <= rid_next;
      rvalid_reg <= rvalid_next;
    end
  end

  assign sram_a            = a_reg;
  assign sram_d_out        = dout_reg;
  assign sram_d_oe         = d_oe_reg;
  assign sram_cs_n         = cs_n_reg;
  assign sram_oe_n         = oe_n_reg;
  assign sram_we_n         = we_n_reg;
  assign sram_be_n         = be_n_reg;
  assign mem_readdata      = rdata_reg;
  assign mem_readdataid    = rid_reg;
  assign mem_readdatavalid = rvalid_reg;

endmodule

// File: tb/tb_async_sram_ctrl.sv
// Bench for async_sram_ctrl: directed table, reset corner sequences and a
// randomized run against a word-array/queue reference model.
module tb_async_sram_ctrl;

  localparam int DW = 32;
  localparam int AW = 18;
  localparam int IW = 2;
  localparam int RW = 2;
  localparam int WW = 1;
  localparam int TA = 1;

  logic          clock = 1'b0;
  logic          rst = 1'b1;
  logic          mem_waitrequest;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [IW-1:0] mem_id = '0;
  logic [AW-1:0] mem_address = '0;
  logic [DW-1:0] mem_writedata = '0;
  logic [3:0]    mem_writedatamask = '0;
  logic [DW-1:0] mem_readdata;
  logic [IW-1:0] mem_readdataid;
  logic          mem_readdatavalid;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d_out;
  logic          sram_d_oe;
  logic [DW-1:0] sram_d_in;
  logic          sram_cs_n, sram_oe_n, sram_we_n;
  logic [3:0]    sram_be_n;

  async_sram_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .ID_W(IW),
    .READ_WAIT(RW), .WRITE_WAIT(WW), .TURNAROUND(TA)
  ) dut (
    .clock(clock), .rst(rst), .mem_waitrequest(mem_waitrequest),
    .mem_read(mem_read), .mem_write(mem_write), .mem_id(mem_id),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_writedatamask(mem_writedatamask), .mem_readdata(mem_readdata),
    .mem_readdataid(mem_readdataid), .mem_readdatavalid(mem_readdatavalid),
    .sram_a(sram_a), .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe),
    .sram_d_in(sram_d_in), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural asynchronous SRAM: combinational read, byte writes while we_n is low.
  bit [DW-1:0] sram_mem [0:(1<<AW)-1];
  assign sram_d_in = (!sram_cs_n && !sram_oe_n) ? sram_mem[sram_a] : '0;
  always @(posedge clock) begin
    if (rst) begin
      sram_mem[18'h00123] <= 32'hDEADBEEF;
      sram_mem[18'h00040] <= 32'hAABBCCDD;
    end else if (!sram_cs_n && !sram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b]) sram_mem[sram_a][8*b +: 8] <= sram_d_out[8*b +: 8];
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [IW-1:0] id,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd, input logic [3:0] m);
    mem_read = rd; mem_write = wr; mem_id = id;
    mem_address = a; mem_writedata = wd; mem_writedatamask = m;
  endtask

  task automatic go_idle();
    drive(1'b0, 1'b0, '0, '0, '0, 4'h0);
  endtask

  typedef struct {
    logic          rd, wr;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0]    mask;
    int            exp_busy, exp_cs, exp_oe, exp_we, exp_doe;
    logic [3:0]    exp_be;
    logic          exp_resp;
    logic [DW-1:0] exp_data;
    logic [IW-1:0] exp_id;
  } vec_t;

  function automatic vec_t mk(logic rd, logic wr, logic [IW-1:0] id, logic [AW-1:0] a,
                              logic [DW-1:0] wd, logic [3:0] m, int busy, int cs, int oe,
                              int we, int doe, logic [3:0] be, logic resp,
                              logic [DW-1:0] d, logic [IW-1:0] rid);
    vec_t v;
    v.rd = rd; v.wr = wr; v.id = id; v.addr = a; v.wdata = wd; v.mask = m;
    v.exp_busy = busy; v.exp_cs = cs; v.exp_oe = oe; v.exp_we = we; v.exp_doe = doe;
    v.exp_be = be; v.exp_resp = resp; v.exp_data = d; v.exp_id = rid;
    return v;
  endfunction

  // Apply one request from idle and observe the following 12 cycles.
  task automatic apply(input vec_t v, input string tag);
    int busy, cs, oe, we, doe, nresp, resp_k;
    logic [3:0] be_seen;
    logic [DW-1:0] rdata;
    logic [IW-1:0] rid;
    busy = 0; cs = 0; oe = 0; we = 0; doe = 0; nresp = 0; resp_k = -1;
    be_seen = 4'hF; rdata = '0; rid = '0;
    drive(v.rd, v.wr, v.id, v.addr, v.wdata, v.mask);
    @(negedge clock);
    chk({tag, "_accept_wait"}, mem_waitrequest, 0);
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      go_idle();
      @(negedge clock);
      if (mem_waitrequest) busy++;
      if (!sram_cs_n) cs++;
      if (!sram_oe_n) oe++;
      if (!sram_we_n) begin we++; be_seen = sram_be_n; end
      if (sram_d_oe) doe++;
      if (mem_readdatavalid) begin nresp++; resp_k = k; rdata = mem_readdata; rid = mem_readdataid; end
      chk({tag, "_oe_doe_overlap"}, !sram_oe_n && sram_d_oe, 0);
    end
    chk({tag, "_busy"}, busy, v.exp_busy);
    chk({tag, "_cs_cycles"}, cs, v.exp_cs);
    chk({tag, "_oe_cycles"}, oe, v.exp_oe);
    chk({tag, "_we_cycles"}, we, v.exp_we);
    chk({tag, "_doe_cycles"}, doe, v.exp_doe);
    chk({tag, "_resp_count"}, nresp, v.exp_resp ? 1 : 0);
    if (v.exp_we > 0) chk({tag, "_be_n"}, be_seen, v.exp_be);
    if (v.exp_resp) begin
      chk({tag, "_resp_latency"}, resp_k, RW + 1);
      chk({tag, "_rdata"}, rdata, v.exp_data);
      chk({tag, "_rid"}, rid, v.exp_id);
    end
    @(posedge clock); #1;
  endtask

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
    logic [IW-1:0] id;
  } resp_t;

  vec_t vecs [9];
  bit [DW-1:0] ref_mem [0:(1<<AW)-1];
  resp_t rq [$];

  initial begin
    int busy_until, c, r;
    logic rd, wr, exp_v;
    logic [IW-1:0] id;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic [3:0] m;

    // Directed table: {rd, wr, id, addr, wdata, mask, busy, cs, oe, we, doe, be_n, resp, data, id}
    vecs[0] = mk(1, 0, 2, 18'h00123, 0, 0, 2, 2, 2, 0, 0, 4'hF, 1, 32'hDEADBEEF, 2);
    vecs[1] = mk(0, 1, 0, 18'h3FFFF, 32'h11223344, 4'b0101, 4, 3, 0, 1, 3, 4'b1010, 0, 0, 0);
    vecs[2] = mk(0, 1, 0, 18'h00040, 32'h11223344, 4'b0101, 4, 3, 0, 1, 3, 4'b1010, 0, 0, 0);
    vecs[3] = mk(1, 0, 1, 18'h00040, 0, 0, 2, 2, 2, 0, 0, 4'hF, 1, 32'hAA22CC44, 1);
    vecs[4] = mk(0, 1, 0, 18'h00050, 32'hCAFEF00D, 4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0);
    vecs[5] = mk(1, 0, 3, 18'h3FFFF, 0, 0, 2, 2, 2, 0, 0, 4'hF, 1, 32'h00220044, 3);
    vecs[6] = mk(1, 1, 0, 18'h00041, 32'hFFFFFFFF, 4'b1111, 4, 3, 0, 1, 3, 4'b0000, 0, 0, 0);
    vecs[7] = mk(1, 0, 0, 18'h00041, 0, 0, 2, 2, 2, 0, 0, 4'hF, 1, 32'hFFFFFFFF, 0);
    vecs[8] = mk(1, 1, 2, 18'h00042, 32'h12345678, 4'b0000, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0);

    // Reset held 3 cycles with a pending read.
    drive(1'b1, 1'b0, 2'd1, 18'h00123, '0, 4'h0);
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("rst_wait", mem_waitrequest, 1);
      chk("rst_cs_n", sram_cs_n, 1);
      chk("rst_valid", mem_readdatavalid, 0);
      @(posedge clock);
    end
    #1;
    go_idle();
    @(negedge clock);
    chk("rst_sram_a", sram_a, 0);
    chk("rst_d_out", sram_d_out, 0);
    chk("rst_rdata", mem_readdata, 0);
    chk("rst_be_n", sram_be_n, 4'hF);
    chk("rst_d_oe", sram_d_oe, 0);
    @(posedge clock); #1;
    rst = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // Zero-mask write followed immediately by a read.
    drive(1'b0, 1'b1, 0, 18'h00055, 32'h99999999, 4'h0);
    @(negedge clock);
    chk("nop_wait", mem_waitrequest, 0);
    @(posedge clock); #1;
    drive(1'b1, 1'b0, 2'd1, 18'h00123, '0, 4'h0);
    @(negedge clock);
    chk("nop_next_accept", mem_waitrequest, 0);
    chk("nop_cs_n", sram_cs_n, 1);
    chk("nop_we_n", sram_we_n, 1);
    chk("nop_d_oe", sram_d_oe, 0);
    @(posedge clock); #1;
    go_idle();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk("nop_rd_valid", mem_readdatavalid, k == RW + 1);
      if (k == RW + 1) chk("nop_rd_data", mem_readdata, 32'hDEADBEEF);
      @(posedge clock); #1;
    end

    // Reset during a read: the response is dropped.
    drive(1'b1, 1'b0, 2'd1, 18'h00123, '0, 4'h0);
    @(posedge clock); #1;
    go_idle();
    rst = 1'b1;
    @(negedge clock);
    chk("rdabort_busy", mem_waitrequest, 1);
    @(posedge clock); #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("rdabort_valid", mem_readdatavalid, 0);
      chk("rdabort_cs_n", sram_cs_n, 1);
      @(posedge clock); #1;
    end

    // Reset during the write pulse.
    drive(1'b0, 1'b1, 0, 18'h00077, 32'h5A5A5A5A, 4'hF);
    @(posedge clock); #1;
    go_idle();
    @(negedge clock);
    chk("wabort_setup_we_n", sram_we_n, 1);
    chk("wabort_setup_d_oe", sram_d_oe, 1);
    @(posedge clock); #1;
    rst = 1'b1;
    @(negedge clock);
    chk("wabort_pulse_we_n", sram_we_n, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("wabort_we_n", sram_we_n, 1);
    chk("wabort_d_oe", sram_d_oe, 0);
    chk("wabort_wait", mem_waitrequest, 1);
    @(posedge clock); #1;
    rst = 1'b0;
    apply(vecs[0], "post_rst_read");

    // Randomized run against the reference model, addresses 0x100..0x10F.
    busy_until = cyc - 1;
    for (int k = 0; k < 600; k++) begin
      r = $urandom_range(0, 9);
      a = AW'(18'h00100 + $urandom_range(0, 15));
      id = IW'($urandom_range(0, 3));
      wd = $urandom;
      m = 4'($urandom_range(1, 15));
      rd = (r >= 3 && r <= 5) || r == 9;
      wr = (r >= 6);
      if (r == 8) m = 4'h0;
      drive(rd, wr, id, a, wd, m);
      @(negedge clock);
      c = cyc;
      chk("rnd_wait", mem_waitrequest, c <= busy_until);
      chk("rnd_oe_doe_overlap", !sram_oe_n && sram_d_oe, 0);
      chk("rnd_we_without_doe", !sram_we_n && !sram_d_oe, 0);
      exp_v = (rq.size() > 0) && (rq[0].cyc == c);
      chk("rnd_valid", mem_readdatavalid, exp_v);
      if (exp_v) begin
        chk("rnd_rdata", mem_readdata, rq[0].data);
        chk("rnd_rid", mem_readdataid, rq[0].id);
        void'(rq.pop_front());
      end
      if ((rd || wr) && c > busy_until) begin
        if (wr) begin
          if (m != 4'h0) begin
            for (int b = 0; b < 4; b++)
              if (m[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
            busy_until = c + 2 + WW + TA;
          end
        end else begin
          rq.push_back('{c + RW + 1, ref_mem[a], id});
          busy_until = c + RW;
        end
      end
      @(posedge clock); #1;
    end
    go_idle();
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      c = cyc;
      exp_v = (rq.size() > 0) && (rq[0].cyc == c);
      chk("drain_valid", mem_readdatavalid, exp_v);
      if (exp_v) begin
        chk("drain_rdata", mem_readdata, rq[0].data);
        void'(rq.pop_front());
      end
      @(posedge clock); #1;
    end
    chk("drain_pending", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/async_sram_ctrl.md
ASYNC_SRAM_CTRL -- requirements
Module: async_sram_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the SRAM data width in bits; it SHALL be a multiple of 8 and at least 8.
REQ-002 SHALL have parameter ADDR_W, default 18, the SRAM word address width.
REQ-003 SHALL have parameter ID_W, default 2, the width of the request/response tag.
REQ-004 SHALL have parameter READ_WAIT, default 2, the number of cycles oe_n is held low per read; it SHALL be at least 1.
REQ-005 SHALL have parameter WRITE_WAIT, default 1, the number of cycles we_n is held low per write; it SHALL be at least 1.
REQ-006 SHALL have parameter TURNAROUND, default 1, the number of bus-idle cycles inserted after each write; it SHALL be at least 0.
REQ-007 SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-008 SHALL have port rst, input, 1 bit: synchronous reset, active high.
REQ-009 SHALL have port mem_waitrequest, output, 1 bit: request not accepted this cycle.
REQ-010 SHALL have ports mem_read and mem_write, inputs, 1 bit each: request strobes.
REQ-011 SHALL have port mem_id, input, ID_W bits: tag of the read request.
REQ-012 SHALL have port mem_address, input, ADDR_W bits: word address.
REQ-013 SHALL have ports mem_writedata, input, DATA_W bits, and mem_writedatamask, input, DATA_W/8 bits: write data and byte enables (1 = write the byte).
REQ-014 SHALL have ports mem_readdata, output, DATA_W bits; mem_readdataid, output, ID_W bits; and mem_readdatavalid, output, 1 bit: the read response.
REQ-015 SHALL have ports sram_a, output, ADDR_W bits; sram_d_out, output, DATA_W bits; sram_d_oe, output, 1 bit; sram_d_in, input, DATA_W bits. The tristate buffer is instantiated at the top level.
REQ-016 SHALL have ports sram_cs_n, sram_oe_n and sram_we_n, outputs, 1 bit each, and sram_be_n, output, DATA_W/8 bits: all strobes are active low and registered.

Function
REQ-017 A request SHALL be accepted on a rising edge where (mem_read or mem_write) = 1 and mem_waitrequest = 0.
REQ-018 mem_waitrequest SHALL equal (state != IDLE) or rst.
REQ-019 If mem_read and mem_write are both 1, the controller SHALL service the write only; the read is dropped and produces no response.
REQ-020 The FSM SHALL have the states IDLE, READ, WSETUP, WPULSE, WHOLD and TURN, with one shared down-counter.
REQ-021 Read accepted in cycle T: the FSM SHALL be in READ for cycles T+1 to T+READ_WAIT, driving sram_a = address, cs_n = 0, oe_n = 0, be_n = all 0, d_oe = 0.
REQ-022 Read completion: sram_d_in SHALL be registered at the edge ending cycle T+READ_WAIT; mem_readdatavalid SHALL be 1 for exactly cycle T+READ_WAIT+1, carrying the captured data and the captured mem_id; the FSM returns to IDLE in that same cycle.
REQ-023 Write accepted in cycle T: WSETUP SHALL last 1 cycle with a, d_out and be_n = ~mask valid, cs_n = 0, d_oe = 1, we_n = 1.
REQ-024 WPULSE SHALL last WRITE_WAIT cycles with we_n = 0 and all other signals held as in WSETUP.
REQ-025 WHOLD SHALL last 1 cycle with we_n = 1 and a, d_out, d_oe and cs_n held.
REQ-026 After WHOLD, the FSM SHALL enter TURN for TURNAROUND cycles (all strobes deasserted, d_oe = 0), or go directly to IDLE when TURNAROUND = 0.
REQ-027 A write with mask = 0 SHALL be accepted as a no-op: no SRAM strobe is asserted and the FSM stays in IDLE.
REQ-028 sram_oe_n = 0 and sram_d_oe = 1 SHALL never hold in the same cycle; sram_we_n SHALL never be 0 in any state other than WPULSE.
REQ-029 In IDLE and TURN the outputs SHALL be: cs_n = 1, oe_n = 1, we_n = 1, be_n = all 1, d_oe = 0; sram_a and sram_d_out hold their last values.
REQ-030 Maximum read throughput SHALL be one read per READ_WAIT+1 cycles; a write occupies 3+WRITE_WAIT-1+TURNAROUND cycles beyond its accept cycle.

Reset
REQ-031 While rst = 1, at each edge: state SHALL become IDLE, the counter 0, mem_readdatavalid 0, cs_n/oe_n/we_n = 1, be_n = all 1, d_oe = 0, and sram_a, sram_d_out, mem_readdata and mem_readdataid = 0.
REQ-032 Reset asserted mid-operation SHALL abort the operation at the next edge; an in-flight read SHALL produce no response.

Verification
REQ-033 Hold rst = 1 for 3 cycles with mem_read = 1 -> mem_waitrequest = 1 and cs_n = 1 throughout, and no mem_readdatavalid.
REQ-034 Read address 0x00123 with id 2 against a model returning 0xDEADBEEF -> oe_n low for exactly 2 cycles; valid at accept+3 with data 0xDEADBEEF and id 2.
REQ-035 Write address 0x3FFFF, data 0x11223344, mask 4'b0101 -> be_n = 4'b1010, we_n low for exactly 1 cycle, d_oe high for cycles T+1 to T+3, TURN at T+4, next accept at T+5.
REQ-036 Write then read of the same address over a model preloaded with 0xAABBCCDD -> read returns 0xAA22CC44, and oe_n and d_oe never overlap.
REQ-037 Write with mask 0 followed by a read -> no strobes for the write, and the read is accepted on the next cycle.
REQ-038 Assert rst during WPULSE -> we_n = 1, d_oe = 0 and waitrequest = 1 at the next edge; after reset release, a read completes normally.
